// File: rtl/alu16_result_fifo.sv
// Result FIFO behind a 16-bit ALU: buffers {op, y, v, c, z} with no input backpressure.
// Overflowing pushes are dropped and recorded in ovf_sticky. Head entry is registered.
// Optional per-flag event counters are enabled by defining ALU16_FLAG_CNT_EN.
module alu16_result_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [3:0]                 in_op,
    input  logic [15:0]                in_y,
    input  logic                       in_z,
    input  logic                       in_c,
    input  logic                       in_v,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_op,
    output logic [15:0]                out_y,
    output logic [2:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_sticky,
    input  logic                       clr_ovf
`ifdef ALU16_FLAG_CNT_EN
    ,
    input  logic                       clr_cnt,
    output logic [15:0]                cnt_z,
    output logic [15:0]                cnt_c,
    output logic [15:0]                cnt_v
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] Full = CW'(DEPTH);
    localparam logic [CW-1:0] One  = CW'(1);

    logic [3:0]    mem_op    [DEPTH];
    logic [15:0]   mem_y     [DEPTH];
    logic [2:0]    mem_flags [DEPTH];

    logic [AW-1:0] rd_ptr_q, wr_ptr_q, rd_next;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    head_op_q, head_op_d;
    logic [15:0]   head_y_q, head_y_d;
    logic [2:0]    head_flags_q, head_flags_d;
    logic [2:0]    in_flags;
    logic          pop, push, drop;

    assign in_flags = {in_v, in_c, in_z};
    assign rd_next  = rd_ptr_q + AW'(1);

    // Handshake decode, occupancy, sticky overflow and next head entry.
    always_comb begin
        pop          = (count_q != '0) && out_ready;
        push         = in_valid && ((count_q < Full) || pop);
        drop         = in_valid && !push;
        count_d      = count_q;
        ovf_d        = ovf_q;
        head_op_d    = head_op_q;
        head_y_d     = head_y_q;
        head_flags_d = head_flags_q;

        if (push && !pop) begin
            count_d = count_q + One;
        end else if (pop && !push) begin
            count_d = count_q - One;
        end

        // A drop wins over a same-cycle clear.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        // Head only changes when a new entry becomes head; when draining to empty it holds.
        if (pop && (count_q > One)) begin
            head_op_d    = mem_op[rd_next];
            head_y_d     = mem_y[rd_next];
            head_flags_d = mem_flags[rd_next];
        end else if (push && ((count_q == '0) || (pop && (count_q == One)))) begin
            head_op_d    = in_op;
            head_y_d     = in_y;
            head_flags_d = in_flags;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr_q]    <= in_op;
            mem_y[wr_ptr_q]     <= in_y;
            mem_flags[wr_ptr_q] <= in_flags;
        end
    end

    // Pointers, occupancy, sticky flag and registered head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            head_op_q    <= '0;
            head_y_q     <= '0;
            head_flags_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_next;
            end
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            head_op_q    <= head_op_d;
            head_y_q     <= head_y_d;
            head_flags_q <= head_flags_d;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_op     = head_op_q;
    assign out_y      = head_y_q;
    assign out_flags  = head_flags_q;
    assign count      = count_q;
    assign ovf_sticky = ovf_q;

`ifdef ALU16_FLAG_CNT_EN
    logic [15:0] cnt_z_q, cnt_c_q, cnt_v_q;

    // Saturating per-flag counters over accepted pushes; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_z_q <= '0;
            cnt_c_q <= '0;
            cnt_v_q <= '0;
        end else if (clr_cnt) begin
            cnt_z_q <= '0;
            cnt_c_q <= '0;
            cnt_v_q <= '0;
        end else if (push) begin
            if (in_z && (cnt_z_q != 16'hFFFF)) cnt_z_q <= cnt_z_q + 16'd1;
            if (in_c && (cnt_c_q != 16'hFFFF)) cnt_c_q <= cnt_c_q + 16'd1;
            if (in_v && (cnt_v_q != 16'hFFFF)) cnt_v_q <= cnt_v_q + 16'd1;
        end
    end

    assign cnt_z = cnt_z_q;
    assign cnt_c = cnt_c_q;
    assign cnt_v = cnt_v_q;
`endif

endmodule

// File: tb/tb_alu16_result_fifo.sv
// Randomized and directed bench for alu16_result_fifo against a queue-based reference model.
// Counter checks are compiled in when ALU16_FLAG_CNT_EN is defined.
module tb_alu16_result_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_z, in_c, in_v, out_ready, clr_ovf;
    logic [3:0]  in_op;
    logic [15:0] in_y;
    logic        out_valid, ovf_sticky;
    logic [3:0]  out_op;
    logic [15:0] out_y;
    logic [2:0]  out_flags;
    logic [2:0]  count;
`ifdef ALU16_FLAG_CNT_EN
    logic        clr_cnt;
    logic [15:0] cnt_z, cnt_c, cnt_v;
    int          m_cz, m_cc, m_cv;
`endif

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] y;
        logic [2:0]  flags;
    } ent_t;

    ent_t q[$];
    ent_t last_head;
    logic m_ovf;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu16_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_op      (in_op),
        .in_y       (in_y),
        .in_z       (in_z),
        .in_c       (in_c),
        .in_v       (in_v),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_y      (out_y),
        .out_flags  (out_flags),
        .count      (count),
        .ovf_sticky (ovf_sticky),
        .clr_ovf    (clr_ovf)
`ifdef ALU16_FLAG_CNT_EN
        ,
        .clr_cnt    (clr_cnt),
        .cnt_z      (cnt_z),
        .cnt_c      (cnt_c),
        .cnt_v      (cnt_v)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        ent_t h;
        h = (q.size() != 0) ? q[0] : last_head;
        check("count", 32'(count), 32'(q.size()));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
        check("out_y", 32'(out_y), 32'(h.y));
        check("out_op", 32'(out_op), 32'(h.op));
        check("out_flags", 32'(out_flags), 32'(h.flags));
`ifdef ALU16_FLAG_CNT_EN
        check("cnt_z", 32'(cnt_z), 32'(m_cz));
        check("cnt_c", 32'(cnt_c), 32'(m_cc));
        check("cnt_v", 32'(cnt_v), 32'(m_cv));
`endif
    endtask

    // One clock: drive inputs, advance the model by the rules, compare everything.
    task automatic cycle(input logic v, input logic [3:0] op, input logic [15:0] y,
                         input logic z, input logic c, input logic fv,
                         input logic rdy, input logic clr);
        logic pop, push;
        in_valid = v; in_op = op; in_y = y; in_z = z; in_c = c; in_v = fv;
        out_ready = rdy; clr_ovf = clr;
        pop  = (q.size() != 0) && rdy;
        push = v && ((q.size() < DEPTH) || pop);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{op: op, y: y, flags: {fv, c, z}});
        if (v && !push) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
`ifdef ALU16_FLAG_CNT_EN
        if (clr_cnt) begin
            m_cz = 0; m_cc = 0; m_cv = 0;
        end else if (push) begin
            if (z && m_cz < 65535) m_cz++;
            if (c && m_cc < 65535) m_cc++;
            if (fv && m_cv < 65535) m_cv++;
        end
`endif
        if (q.size() != 0) last_head = q[0];
        compare_all();
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic push_y(input logic [15:0] y, input logic rdy);
        cycle(1'b1, y[3:0], y, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Pop the head, first confirming it carries the expected word.
    task automatic expect_pop(input string tag, input logic [15:0] y);
        check(tag, 32'(out_y), 32'(y));
        idle(1'b1);
    endtask

    task automatic model_reset();
        q.delete();
        last_head = '0;
        m_ovf = 1'b0;
`ifdef ALU16_FLAG_CNT_EN
        m_cz = 0; m_cc = 0; m_cv = 0;
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = '0; in_y = '0; in_z = 1'b0; in_c = 1'b0; in_v = 1'b0;
        out_ready = 1'b0; clr_ovf = 1'b0;
`ifdef ALU16_FLAG_CNT_EN
        clr_cnt = 1'b0;
`endif
        model_reset();
        #12;
        rst_n = 1'b1;
        compare_all();

        // Basic latency
        cycle(1'b1, 4'h0, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_y", 32'(out_y), 32'h1234);
        check("lat_flags", 32'(out_flags), 32'b010);
        check("lat_count", 32'(count), 32'd1);
        idle(1'b1);

        // Fill and drop
        for (int i = 1; i <= 5; i++) push_y(16'(i), 1'b0);
        check("fill_count", 32'(count), 32'd4);
        check("fill_ovf", 32'(ovf_sticky), 32'd1);
        for (int i = 1; i <= 4; i++) expect_pop("fill_order", 16'(i));
        check("fill_empty", 32'(out_valid), 32'd0);
        cycle(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", 32'(ovf_sticky), 32'd0);

        // Full push+pop, then sticky priority while still full
        for (int i = 1; i <= 4; i++) push_y(16'(i), 1'b0);
        push_y(16'd9, 1'b1);
        check("fpp_ovf", 32'(ovf_sticky), 32'd0);
        check("fpp_count", 32'(count), 32'd4);
        push_y(16'd7, 1'b0);
        check("drop_ovf", 32'(ovf_sticky), 32'd1);
        cycle(1'b1, 4'h8, 16'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("drop_beats_clr", 32'(ovf_sticky), 32'd1);
        cycle(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_no_drop", 32'(ovf_sticky), 32'd0);
        expect_pop("fpp_order", 16'd2);
        expect_pop("fpp_order", 16'd3);
        expect_pop("fpp_order", 16'd4);
        expect_pop("fpp_order", 16'd9);

        // Reset mid-stream
        for (int i = 1; i <= 3; i++) push_y(16'(i + 16'h40), 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_y", 32'(out_y), 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        push_y(16'hBEEF, 1'b0);
        check("rst_next", 32'(out_y), 32'hBEEF);
        idle(1'b1);

`ifdef ALU16_FLAG_CNT_EN
        clr_cnt = 1'b1;
        idle(1'b1);
        clr_cnt = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'h1, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 4'h2, 16'h5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("cnt_z3", 32'(cnt_z), 32'd3);
        check("cnt_c1", 32'(cnt_c), 32'd1);
        check("cnt_v1", 32'(cnt_v), 32'd1);
        for (int i = 0; i < 65536; i++) cycle(1'b1, 4'h1, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("cnt_sat", 32'(cnt_z), 32'hFFFF);
        // Clear must beat a same-cycle increment.
        clr_cnt = 1'b1;
        cycle(1'b1, 4'h1, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        clr_cnt = 1'b0;
        check("cnt_clr", 32'(cnt_z), 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, 4'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
